// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// funct codes and ALU control values.
package mips_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUC_W  = 3;
  localparam int unsigned ALUOP_W = 2;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALUC_W-1:0] ALU_AND = 3'd0;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'd1;
  localparam logic [ALUC_W-1:0] ALU_ADD = 3'd2;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'd6;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'd7;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

endpackage

// File: rtl/mips_aludec.sv
// ALU control decoder: fixed ADD/SUB requests, or an R-type funct lookup
// that flags unsupported funct codes.
module mips_aludec
  import mips_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALUC_W-1:0]  alucontrol,
  output logic               funct_illegal
);

  always_comb begin
    alucontrol    = ALU_ADD;
    funct_illegal = 1'b0;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives Moore datapath controls, with mem_ready and zero gating strobes.
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     op,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pcen,
  output logic                irwrite,
  output logic                memwrite,
  output logic                regwrite,
  output logic                iord,
  output logic                memtoreg,
  output logic                regdst,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic [ALUC_W-1:0]   alucontrol,
  output logic                illegal,
  output logic [STATE_W-1:0]  state
);

  state_t              state_q, state_d;
  logic [ALUOP_W-1:0]  aluop;
  logic                funct_illegal;

  mips_aludec u_aludec (
    .aluop         (aluop),
    .funct         (funct),
    .alucontrol    (alucontrol),
    .funct_illegal (funct_illegal)
  );

  assign state = STATE_W'(state_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    if (mem_ready) state_d = MEMWB;
      MEMWR:    if (mem_ready) state_d = FETCH;
      EXECUTE:  state_d = funct_illegal ? FETCH : ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    pcen     = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    illegal  = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      DECODE: begin
        alusrcb = 2'b11;
        illegal = ~op_legal(op);
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:    iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = mem_ready;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        illegal = funct_illegal;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        pcen    = zero;
      end
      ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:   regwrite = 1'b1;
      JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    // State is already FETCH under reset; only the strobes need suppressing.
    if (!reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: directed scenarios plus randomized
// instruction streams against an instruction-level reference model.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  mips_mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite),
    .regwrite(regwrite), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: sequence of states an instruction visits, from FETCH onward.
  function automatic void build_path(input logic [5:0] o, input logic [5:0] f,
                                     output int p[$]);
    p = '{0, 1};
    case (o)
      6'b100011: p = '{0, 1, 2, 3, 4};
      6'b101011: p = '{0, 1, 2, 5};
      6'b000000: begin
        if (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) p = '{0, 1, 6, 7};
        else p = '{0, 1, 6};
      end
      6'b000100: p = '{0, 1, 8};
      6'b001000: p = '{0, 1, 9, 10};
      6'b000010: p = '{0, 1, 11};
      default:   p = '{0, 1};
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'h22:   return 3'd6;
      6'h24:   return 3'd0;
      6'h25:   return 3'd1;
      6'h2a:   return 3'd7;
      default: return 3'd2;
    endcase
  endfunction

  // Reference: expected {pcen,irwrite,memwrite,regwrite,iord,memtoreg,regdst,
  // alusrca,alusrcb,pcsrc,alucontrol,illegal} for a state and current inputs.
  function automatic logic [15:0] exp_out(input int s, input logic [5:0] o,
                                          input logic [5:0] f, input logic z,
                                          input logic mr);
    logic pe = 0, ir = 0, mw = 0, rw = 0, io = 0, m2r = 0, rd = 0, sa = 0, il = 0;
    logic [1:0] sb = 0, ps = 0;
    logic [2:0] ac = 3'd2;
    case (s)
      0:  begin sb = 2'b01; ir = mr; pe = mr; end
      1:  begin sb = 2'b11;
                il = !(o inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02}); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  io = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin io = 1; mw = mr; end
      6:  begin sa = 1; ac = funct_alu(f);
                il = !(f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}); end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; ac = 3'd6; ps = 2'b01; pe = z; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {pe, ir, mw, rw, io, m2r, rd, sa, sb, ps, ac, il};
  endfunction

  task automatic test_reset();
    reset = 1'b0; op = 6'b100011; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (state !== 4'd0 || {pcen, irwrite, memwrite, regwrite, illegal} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d state=%0d strobes=%b required state=0 strobes=00000",
                 i, state, {pcen, irwrite, memwrite, regwrite, illegal});
      end
    end
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if (state !== 4'd0 || irwrite !== 1'b1 || pcen !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release state=%0d irwrite=%b pcen=%b required 0/1/1",
               state, irwrite, pcen);
    end
  endtask

  task automatic test_lw();
    int exp_s[5] = '{0, 1, 2, 3, 4};
    op = 6'b100011; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (state !== 4'(exp_s[i])) begin
        n_fail++;
        $display("FAIL lw_state step=%0d got=%0d required=%0d", i, state, exp_s[i]);
      end
      if (i == 2) begin
        n_checks++;
        if (alucontrol !== 3'd2 || alusrcb !== 2'b10) begin
          n_fail++;
          $display("FAIL lw_memadr alucontrol=%0d alusrcb=%b required 2/10", alucontrol, alusrcb);
        end
      end
      if (i == 4) begin
        n_checks++;
        if ({regwrite, memtoreg, regdst} !== 3'b110) begin
          n_fail++;
          $display("FAIL lw_memwb rw/m2r/rd=%b required 110", {regwrite, memtoreg, regdst});
        end
      end
      tick();
    end
    #1;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL lw_return state=%0d required=0", state);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fns[5] = '{6'h2a, 6'h20, 6'h22, 6'h24, 6'h25};
    logic [2:0] acs[5] = '{3'd7, 3'd2, 3'd6, 3'd0, 3'd1};
    op = 6'b000000; mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      funct = fns[k];
      tick();
      tick();
      #1;
      n_checks++;
      if (state !== 4'd6 || alucontrol !== acs[k] || alusrca !== 1'b1 ||
          alusrcb !== 2'b00 || illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL rtype_exec funct=%h state=%0d alucontrol=%0d srca=%b srcb=%b ill=%b required 6/%0d/1/00/0",
                 fns[k], state, alucontrol, alusrca, alusrcb, illegal, acs[k]);
      end
      tick();
      #1;
      n_checks++;
      if (state !== 4'd7 || regwrite !== 1'b1 || regdst !== 1'b1 || memtoreg !== 1'b0) begin
        n_fail++;
        $display("FAIL rtype_wb funct=%h state=%0d rw=%b rd=%b m2r=%b required 7/1/1/0",
                 fns[k], state, regwrite, regdst, memtoreg);
      end
      tick();
    end
  endtask

  task automatic test_beq();
    op = 6'b000100; mem_ready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      zero = 1'(z);
      tick();
      tick();
      #1;
      n_checks++;
      if (state !== 4'd8 || pcen !== 1'(z) || pcsrc !== 2'b01 || alucontrol !== 3'd6) begin
        n_fail++;
        $display("FAIL beq_branch zero=%0d state=%0d pcen=%b pcsrc=%b alucontrol=%0d required 8/%0d/01/6",
                 z, state, pcen, pcsrc, alucontrol, z);
      end
      tick();
      #1;
      n_checks++;
      if (state !== 4'd0) begin
        n_fail++;
        $display("FAIL beq_return zero=%0d state=%0d required=0", z, state);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_sw_wait();
    op = 6'b101011; mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (state !== 4'd5 || memwrite !== 1'b0) begin
        n_fail++;
        $display("FAIL sw_wait cyc=%0d state=%0d memwrite=%b required 5/0", i, state, memwrite);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (state !== 4'd5 || memwrite !== 1'b1 || iord !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_write state=%0d memwrite=%b iord=%b required 5/1/1", state, memwrite, iord);
    end
    tick();
    #1;
    n_checks++;
    if (state !== 4'd0 || memwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_return state=%0d memwrite=%b required 0/0", state, memwrite);
    end
  endtask

  task automatic test_illegal();
    op = 6'b111111; mem_ready = 1'b1;
    tick();
    #1;
    n_checks++;
    if (state !== 4'd1 || illegal !== 1'b1 || regwrite !== 1'b0 || memwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_op state=%0d ill=%b rw=%b mw=%b required 1/1/0/0",
               state, illegal, regwrite, memwrite);
    end
    tick();
    #1;
    n_checks++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_op_return state=%0d ill=%b required 0/0", state, illegal);
    end
    op = 6'b000000; funct = 6'b000000;
    tick();
    tick();
    #1;
    n_checks++;
    if (state !== 4'd6 || illegal !== 1'b1 || alucontrol !== 3'd2) begin
      n_fail++;
      $display("FAIL illegal_funct state=%0d ill=%b alucontrol=%0d required 6/1/2",
               state, illegal, alucontrol);
    end
    tick();
    #1;
    n_checks++;
    if (state !== 4'd0 || regwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_funct_nowb state=%0d rw=%b required 0/0", state, regwrite);
    end
  endtask

  task automatic test_reset_mid();
    op = 6'b100011; mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd3) begin
      n_fail++;
      $display("FAIL reset_mid_pre state=%0d required=3", state);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd0 || {pcen, irwrite, memwrite, regwrite} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async state=%0d strobes=%b required 0/0000",
               state, {pcen, irwrite, memwrite, regwrite});
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic [5:0] ops[7] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h00};
    logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    int path[$];
    for (int n = 0; n < 60; n++) begin
      int k = int'($urandom_range(0, 7));
      int idx = 0;
      int guard = 0;
      op    = (k < 7) ? ops[k] : 6'($urandom);
      funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      build_path(op, funct, path);
      while (idx < path.size() && guard < 40) begin
        int s = path[idx];
        logic [15:0] exp_v, act_v;
        mem_ready = ($urandom_range(0, 3) != 0);
        zero      = 1'($urandom);
        #1;
        exp_v = exp_out(s, op, funct, zero, mem_ready);
        act_v = {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
                 alusrca, alusrcb, pcsrc, alucontrol, illegal};
        n_checks++;
        if (state !== 4'(s) || act_v !== exp_v) begin
          n_fail++;
          $display("FAIL random_step op=%h funct=%h state=%0d outs=%h required state=%0d outs=%h",
                   op, funct, state, act_v, s, exp_v);
        end
        n_checks++;
        if ((memwrite && regwrite) || (irwrite && state != 4'd0) ||
            (pcen && !(state inside {4'd0, 4'd8, 4'd11}))) begin
          n_fail++;
          $display("FAIL random_invariant state=%0d mw=%b rw=%b ir=%b pcen=%b",
                   state, memwrite, regwrite, irwrite, pcen);
        end
        if (!((s == 0 || s == 3 || s == 5) && !mem_ready)) idx++;
        tick();
        guard++;
      end
      n_checks++;
      if (idx < path.size()) begin
        n_fail++;
        $display("FAIL random_timeout op=%h reached=%0d required=%0d", op, idx, path.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_sw_wait();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multicycle MIPS control unit. It decodes the instruction register's opcode/funct, sequences the datapath through fetch/decode/execute/memory/writeback states, and drives the 3-bit ALU control code. It consumes the ALU's zero flag for branch resolution. It sits between instruction memory/IR and the shared datapath, and is the producer of every ALU operation request.

Parameters:
(none; all encodings are fixed constants in mips_pkg)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
op  in  6  instruction opcode, IR[31:26]
funct  in  6  instruction funct, IR[5:0]
zero  in  1  ALU zero flag, 1 when ALU result == 0
mem_ready  in  1  memory access completes this cycle
pcen  out  1  PC register load enable
irwrite  out  1  IR load enable
memwrite  out  1  data memory write strobe
regwrite  out  1  register file write enable
iord  out  1  memory address select: 0=PC, 1=ALUOut
memtoreg  out  1  writeback select: 0=ALUOut, 1=memory data
regdst  out  1  destination select: 0=rt, 1=rd
alusrca  out  1  ALU A select: 0=PC, 1=rs
alusrcb  out  2  ALU B select: 00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2
pcsrc  out  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target
alucontrol  out  3  ALU op: 0=AND, 1=OR, 2=ADD, 6=SUB, 7=SLT
illegal  out  1  one-cycle pulse on an unsupported op or funct
state  out  4  current state, for debug/verification

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset=0). While reset=0, state=FETCH and pcen, irwrite, memwrite, regwrite and illegal are forced to 0. The other outputs take their FETCH values.
- Output style: Moore outputs decoded from state, with two exceptions:
  - mem_ready gates irwrite, pcen and memwrite.
  - zero gates pcen in BRANCH.
- Unlisted outputs default to 0, except alucontrol, which defaults to ADD (2).
- States and per-state outputs:
  - FETCH: iord=0, alusrca=0, alusrcb=01, ADD, pcsrc=00. irwrite=pcen=mem_ready. Stay in FETCH while mem_ready=0; otherwise go to DECODE.
  - DECODE: alusrca=0, alusrcb=11, ADD (precomputes the branch target). Next state by op:
    - lw/sw → MEMADR
    - R-type → EXECUTE
    - beq → BRANCH
    - addi → ADDIEXEC
    - j → JUMP
    - anything else → FETCH, with illegal=1 for this cycle
  - MEMADR: alusrca=1, alusrcb=10, ADD. Next is MEMRD for lw, MEMWR for sw.
  - MEMRD: iord=1. Hold while mem_ready=0, then go to MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1, then FETCH.
  - MEMWR: iord=1, memwrite=mem_ready. Hold while mem_ready=0, then FETCH.
  - EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct:
    - 100000 → ADD
    - 100010 → SUB
    - 100100 → AND
    - 100101 → OR
    - 101010 → SLT
    - other funct → ADD, illegal=1, next state FETCH (no writeback)
    - a legal funct goes to ALUWB
  - ALUWB: regdst=1, memtoreg=0, regwrite=1, then FETCH.
  - BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01, pcen=zero, then FETCH.
  - ADDIEXEC: alusrca=1, alusrcb=10, ADD, then ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1, then FETCH.
  - JUMP: pcsrc=10, pcen=1, then FETCH.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Latency with mem_ready held at 1, counted from FETCH:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
  - illegal op: 2 cycles
  - Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Invariants:
  - At most one of memwrite/regwrite is high per cycle.
  - irwrite is high only in FETCH.
  - pcen is never high outside FETCH, BRANCH and JUMP.
- Reset mid-instruction: state returns to FETCH immediately (asynchronous). No write enable glitches high during reset assertion. The first FETCH begins on the first clk edge after reset deasserts.
- op/funct are sampled combinationally from the IR. The IR is stable after FETCH, so no internal latching is needed.

Decomposition:
- mips_pkg holds:
  - state_t enum (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11
  - opcode and funct localparams
  - ALU control constants ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7
- One sub-module, mips_aludec: combinational, takes aluop[1:0] (00=ADD, 01=SUB, 10=use funct) and funct, produces alucontrol and funct_illegal.
- The FSM holds the state register, next-state logic and output decode.

Test Plan:
- Reset: hold reset=0 for 3 cycles with op=lw and mem_ready=1 → state=FETCH and pcen=irwrite=memwrite=regwrite=0 throughout. Release reset → cycle 1 has irwrite=pcen=1.
- lw (op=100011), mem_ready=1 → state sequence 0,1,2,3,4,0. In MEMADR, alucontrol=2 and alusrcb=10. In MEMWB, regwrite=1, memtoreg=1, regdst=0.
- R-type slt (op=000000, funct=101010) → EXECUTE has alucontrol=7, alusrca=1, alusrcb=00. ALUWB has regwrite=1, regdst=1. Repeat for funct 100000/100010/100100/100101 → alucontrol 2/6/0/1.
- beq (op=000100): with zero=1 in BRANCH → pcen=1, pcsrc=01, alucontrol=6. With zero=0 → pcen=0. Next state is FETCH in both cases.
- Wait states: sw with mem_ready=0 for 3 cycles in MEMWR → state held at 5 with memwrite=0. When mem_ready=1, memwrite pulses for exactly 1 cycle, then FETCH.
- Illegal cases:
  - op=111111 → illegal=1 for the DECODE cycle, then FETCH, with no regwrite/memwrite.
  - R-type with funct=000000 → illegal=1 in EXECUTE, no ALUWB.
  - Async reset asserted mid-MEMRD → state=FETCH within the same cycle.
